// File: rtl/control_pkg.sv
// Shared definitions for the counter sequencer.
//   state_t      : sequencer states (IDLE, RUN, FIN)
//   WIDTH_DEF    : default width of count, target and c
//   PRESC_W_DEF  : default width of divisor and of the prescaler
package control_pkg;

  localparam int WIDTH_DEF   = 5;
  localparam int PRESC_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/control_contador_divisor_tick.sv
// Prescaler that paces the enable pulses of the sequencer.
//   clk      : system clock
//   rst      : asynchronous active-high reset
//   clear    : restart the prescaler phase (issued with each new command)
//   run      : prescaler advances and may tick only while high
//   divisor  : gap between ticks minus 1
//   tick     : 1-cycle pulse, first one in the cycle right after clear,
//              then every divisor+1 cycles
module divisor_tick
  import control_pkg::*;
#(
  parameter int PRESC_W = PRESC_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               run,
  input  logic [PRESC_W-1:0] divisor,
  output logic               tick
);

  logic [PRESC_W-1:0] presc;

  // The tick fires at phase 0 so the first pulse follows the command
  // immediately; the phase wraps after reaching divisor, giving a period of
  // divisor+1. The full PRESC_W compare makes divisor=all-ones legal.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
    end else if (clear) begin
      presc <= '0;
    end else if (run) begin
      presc <= (presc == divisor) ? '0 : presc + PRESC_W'(1);
    end
  end

  assign tick = run && (presc == '0);

endmodule

// File: rtl/control_contador.sv
// Sequencer for the 5-bit up-counter datapath. A start command issues exactly
// `target` enable pulses spaced divisor+1 clocks apart, mirrors the running
// count, pulses done on completion and supports abort via stop.
//   clk      : system clock, all logic on posedge
//   rst      : asynchronous active-high reset
//   start    : command strobe, sampled only in IDLE
//   stop     : abort request, sampled only in RUN
//   target   : number of enable pulses, latched on start
//   divisor  : gap between pulses minus 1, latched on start
//   en_out   : 1-cycle enable pulses to the counter
//   c        : pulses issued since last start
//   busy     : sequencer not idle
//   done     : 1-cycle pulse when target reached
//   aborted  : 1-cycle pulse when the run was ended by stop
module control_contador
  import control_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int PRESC_W = PRESC_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [WIDTH-1:0]   target,
  input  logic [PRESC_W-1:0] divisor,
  output logic               en_out,
  output logic [WIDTH-1:0]   c,
  output logic               busy,
  output logic               done,
  output logic               aborted
);

  state_t             state, state_n;
  logic [WIDTH-1:0]   tgt_q, tgt_n, c_n, c_inc;
  logic [PRESC_W-1:0] div_q, div_n;
  logic               aborted_n, clear, run, tick;

  assign run = (state == RUN);

  divisor_tick #(.PRESC_W(PRESC_W)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .run     (run),
    .divisor (div_q),
    .tick    (tick)
  );

  // State register, command latch, count mirror and the registered abort
  // flag. Everything clears asynchronously so a mid-run reset silences
  // en_out at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      tgt_q   <= '0;
      div_q   <= '0;
      c       <= '0;
      aborted <= 1'b0;
    end else begin
      state   <= state_n;
      tgt_q   <= tgt_n;
      div_q   <= div_n;
      c       <= c_n;
      aborted <= aborted_n;
    end
  end

  // Next-state logic. In RUN a pulse on the stop edge is still counted, and
  // when that pulse is the final one completion takes precedence over abort.
  always_comb begin
    state_n   = state;
    tgt_n     = tgt_q;
    div_n     = div_q;
    c_n       = c;
    aborted_n = 1'b0;
    clear     = 1'b0;
    c_inc     = c + WIDTH'(1);
    case (state)
      IDLE: begin
        if (start) begin
          tgt_n   = target;
          div_n   = divisor;
          c_n     = '0;
          clear   = 1'b1;
          state_n = (target == '0) ? FIN : RUN;
        end
      end
      RUN: begin
        if (tick) begin
          c_n = c_inc;
        end
        if (tick && (c_inc == tgt_q)) begin
          state_n = FIN;
        end else if (stop) begin
          state_n   = IDLE;
          aborted_n = 1'b1;
        end
      end
      FIN: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign en_out = tick;
  assign busy   = (state != IDLE);
  assign done   = (state == FIN);

endmodule

// File: tb/tb_control_contador.sv
// Self-checking bench for control_contador: an arithmetic model predicts
// every output from the command timing, plus literal spot checks.
module tb_control_contador;

  logic       clk = 1'b0;
  logic       rst, start, stop;
  logic [4:0] target;
  logic [7:0] divisor;
  logic       en_out, busy, done, aborted;
  logic [4:0] c;

  int checks = 0, errors = 0;
  int pulseCount = 0;

  // Model: command issued at edge e0 with target mT, divisor mD; r counts
  // cycles since that edge (r=0 is the first cycle after it).
  int  e = 0, e0 = 0, mT = 0, mD = 0, stopR = 0, rCur = 0, rNow = 0;
  bit  hasCmd = 1'b0, stopSet = 1'b0;

  control_contador dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .stop    (stop),
    .target  (target),
    .divisor (divisor),
    .en_out  (en_out),
    .c       (c),
    .busy    (busy),
    .done    (done),
    .aborted (aborted)
  );

  always #5 clk = ~clk;

  function automatic int lastR();
    return (mT - 1) * (mD + 1);
  endfunction

  function automatic int limitR();
    return stopSet ? stopR : lastR();
  endfunction

  function automatic int endR();
    if (mT == 0) return 0;
    if (stopSet) return stopR;
    return lastR() + 1;
  endfunction

  function automatic bit expBusy(input int r);
    return hasCmd && (r <= endR());
  endfunction

  function automatic bit expEn(input int r);
    return hasCmd && (mT != 0) && (r % (mD + 1) == 0) && (r <= limitR());
  endfunction

  function automatic int expC(input int r);
    int m;
    if (!hasCmd || mT == 0 || r < 1) return 0;
    m = (r - 1 < limitR()) ? r - 1 : limitR();
    return m / (mD + 1) + 1;
  endfunction

  function automatic bit expDone(input int r);
    return hasCmd && !stopSet && (r == endR());
  endfunction

  function automatic bit expAborted(input int r);
    return hasCmd && stopSet && (r == stopR + 1);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] t, input logic [7:0] d);
    @(negedge clk);
    start   = 1'b1;
    target  = t;
    divisor = d;
    @(negedge clk);
    start   = 1'b0;
    target  = 5'($urandom);
    divisor = 8'($urandom);
  endtask

  task automatic waitIdle(input int budget);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) checkOutput("idle_timeout", busy, 0);
  endtask

  // Model update on each sampling edge: record an effective stop, then
  // accept a start only when the model says the sequencer is idle.
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      hasCmd  = 1'b0;
      stopSet = 1'b0;
    end else begin
      rCur = e - e0;
      if (hasCmd && !stopSet && mT != 0 && stop && rCur < lastR()) begin
        stopSet = 1'b1;
        stopR   = rCur;
      end
      e++;
      if (start && !(hasCmd && rCur <= endR())) begin
        hasCmd  = 1'b1;
        e0      = e;
        mT      = int'(target);
        mD      = int'(divisor);
        stopSet = 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      checkOutput("rst_en_out", en_out, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_aborted", aborted, 0);
      checkOutput("rst_c", c, 0);
    end else begin
      rNow = e - e0;
      checkOutput("en_out", en_out, expEn(rNow));
      checkOutput("busy", busy, expBusy(rNow));
      checkOutput("done", done, expDone(rNow));
      checkOutput("aborted", aborted, expAborted(rNow));
      checkOutput("c", c, expC(rNow));
      if (en_out === 1'b1) pulseCount++;
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; target = '0; divisor = '0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    checkOutput("c_after_reset", c, 0);
    checkOutput("busy_after_reset", busy, 0);

    // Reset in the middle of a run
    applyStimulus(5'd10, 8'd0);
    repeat (3) @(negedge clk);
    checkOutput("en_before_rst", en_out, 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_en_out", en_out, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_done", done, 0);
    checkOutput("midrst_aborted", aborted, 0);
    checkOutput("midrst_c", c, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    checkOutput("c_after_midrst", c, 0);

    // target=3, divisor=0
    pulseCount = 0;
    applyStimulus(5'd3, 8'd0);
    checkOutput("t3d0_first_en", en_out, 1);
    waitIdle(20);
    checkOutput("t3d0_c", c, 3);
    checkOutput("t3d0_pulses", pulseCount, 3);

    // target=2, divisor=3
    pulseCount = 0;
    applyStimulus(5'd2, 8'd3);
    waitIdle(30);
    checkOutput("t2d3_c", c, 2);
    checkOutput("t2d3_pulses", pulseCount, 2);

    // target=0: straight to completion
    pulseCount = 0;
    applyStimulus(5'd0, 8'd5);
    checkOutput("t0_busy", busy, 1);
    checkOutput("t0_done", done, 1);
    checkOutput("t0_en", en_out, 0);
    waitIdle(10);
    checkOutput("t0_c", c, 0);
    checkOutput("t0_pulses", pulseCount, 0);

    // target=31 with an ignored start in the middle
    pulseCount = 0;
    applyStimulus(5'd31, 8'd0);
    repeat (5) @(negedge clk);
    start = 1'b1; target = 5'd2; divisor = 8'd3;
    @(negedge clk);
    start = 1'b0;
    waitIdle(100);
    checkOutput("t31_c", c, 31);
    checkOutput("t31_pulses", pulseCount, 31);

    // Abort on the 3rd pulse edge
    applyStimulus(5'd5, 8'd1);
    repeat (4) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    checkOutput("abort_flag", aborted, 1);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_c", c, 3);
    checkOutput("abort_done", done, 0);
    @(negedge clk);
    checkOutput("abort_flag_once", aborted, 0);

    // Stop on the final pulse edge: completion wins
    applyStimulus(5'd5, 8'd1);
    repeat (8) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    checkOutput("final_stop_done", done, 1);
    checkOutput("final_stop_aborted", aborted, 0);
    checkOutput("final_stop_c", c, 5);
    @(negedge clk);
    checkOutput("final_stop_idle", busy, 0);

    // Largest divisor
    pulseCount = 0;
    applyStimulus(5'd2, 8'd255);
    waitIdle(400);
    checkOutput("d255_c", c, 2);
    checkOutput("d255_pulses", pulseCount, 2);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
